// File: rtl/dm_cmd_sched.sv
// Job-level DataMover command scheduler: splits (saddr, len, chunk) jobs into 72-bit commands, tracks status.
// Latency: first command valid one cycle after job_start; one command per cycle while below the outstanding limit.
// Backpressure: command held stable until accepted; issue pauses at MAX_OUTSTANDING; status always accepted.
module dm_cmd_sched #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 axi_aclk,
    input  logic                 rst,
    input  logic [31:0]          job_saddr,
    input  logic [31:0]          job_len,
    input  logic [22:0]          job_chunk,
    input  logic                 job_start,
    input  logic                 job_abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           err_sts,
    output logic [CNT_WIDTH-1:0] cmd_cnt,
    output logic [71:0]          m_axis_cmd_tdata,
    output logic                 m_axis_cmd_tvalid,
    input  logic                 m_axis_cmd_tready,
    input  logic [7:0]           s_axis_sts_tdata,
    input  logic                 s_axis_sts_tvalid,
    output logic                 s_axis_sts_tready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0]           MAX_O   = 4'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]           state_q;
    logic [31:0]          addr_q;
    logic [31:0]          rem_q;
    logic [22:0]          chunk_q;
    logic [3:0]           outst_q;
    logic                 stop_q;
    logic                 cmd_vld_q;
    logic [71:0]          cmd_dat_q;
    logic [CNT_WIDTH-1:0] cmd_cnt_q;
    logic                 err_q;
    logic [7:0]           err_sts_q;

    logic                 hs;
    logic                 sts_bad;
    logic                 sts_unfl;
    logic [31:0]          btt_cur;
    logic [31:0]          addr_n;
    logic [31:0]          rem_n;
    logic [CNT_WIDTH-1:0] cnt_n;
    logic [3:0]           outst_n;
    logic                 stop_n;
    logic                 issue_ok;
    logic [22:0]          next_btt;
    logic                 next_eof;
    logic [71:0]          next_dat;
    logic [22:0]          start_btt;
    logic                 start_eof;
    logic [71:0]          start_dat;

    // Next-cycle view of the job: address/remaining after this cycle's handshake, counter update, next command word.
    always_comb begin
        hs       = cmd_vld_q & m_axis_cmd_tready;
        sts_bad  = s_axis_sts_tvalid & (~s_axis_sts_tdata[7] | (|s_axis_sts_tdata[6:4]));
        sts_unfl = s_axis_sts_tvalid & (outst_q == 4'd0);
        btt_cur  = {9'd0, cmd_dat_q[22:0]};
        addr_n   = hs ? addr_q + btt_cur : addr_q;
        rem_n    = hs ? rem_q - btt_cur : rem_q;
        cnt_n    = hs ? cmd_cnt_q + CNT_ONE : cmd_cnt_q;

        outst_n = outst_q;
        case ({hs, s_axis_sts_tvalid})
            2'b10:   outst_n = outst_q + 4'd1;
            2'b01:   outst_n = (outst_q != 4'd0) ? outst_q - 4'd1 : 4'd0;
            default: outst_n = outst_q;
        endcase

        // A bad beat or an abort in the same cycle already blocks the next command.
        stop_n   = stop_q | ((state_q == ST_ISSUE) & (job_abort | sts_bad));
        issue_ok = (rem_n != 32'd0) && (outst_n < MAX_O) && !stop_n;

        next_eof = rem_n <= {9'd0, chunk_q};
        next_btt = next_eof ? rem_n[22:0] : chunk_q;
        next_dat = {4'h0, cnt_n[3:0], addr_n, 1'b0, next_eof, 6'h00, 1'b1, next_btt};

        start_eof = job_len <= {9'd0, job_chunk};
        start_btt = start_eof ? job_len[22:0] : job_chunk;
        start_dat = {4'h0, 4'h0, job_saddr, 1'b0, start_eof, 6'h00, 1'b1, start_btt};
    end

    // Job FSM, command register, outstanding tracking and sticky error capture.
    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'd0;
            rem_q     <= 32'd0;
            chunk_q   <= 23'd0;
            outst_q   <= 4'd0;
            stop_q    <= 1'b0;
            cmd_vld_q <= 1'b0;
            cmd_dat_q <= 72'd0;
            cmd_cnt_q <= '0;
            err_q     <= 1'b0;
            err_sts_q <= 8'd0;
        end else begin
            outst_q <= outst_n;
            if (sts_bad || sts_unfl) begin
                err_q <= 1'b1;
                if (!err_q) begin
                    err_sts_q <= s_axis_sts_tdata;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (job_start) begin
                        if (job_chunk == 23'd0) begin
                            err_q     <= 1'b1;
                            err_sts_q <= 8'h00;
                            state_q   <= ST_DONE;
                        end else if (job_len == 32'd0) begin
                            err_q     <= 1'b0;
                            err_sts_q <= 8'h00;
                            state_q   <= ST_DONE;
                        end else begin
                            addr_q    <= job_saddr;
                            rem_q     <= job_len;
                            chunk_q   <= job_chunk;
                            stop_q    <= 1'b0;
                            cmd_cnt_q <= '0;
                            err_q     <= 1'b0;
                            err_sts_q <= 8'h00;
                            cmd_vld_q <= 1'b1;
                            cmd_dat_q <= start_dat;
                            state_q   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    addr_q    <= addr_n;
                    rem_q     <= rem_n;
                    cmd_cnt_q <= cnt_n;
                    stop_q    <= stop_n;
                    if (cmd_vld_q && !hs) begin
                        // Presented command stays valid and stable until accepted.
                        cmd_vld_q <= 1'b1;
                    end else if (issue_ok) begin
                        cmd_vld_q <= 1'b1;
                        cmd_dat_q <= next_dat;
                    end else begin
                        cmd_vld_q <= 1'b0;
                        if ((rem_n == 32'd0) || stop_n) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (outst_n == 4'd0) begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy              = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done              = (state_q == ST_DONE);
    assign err               = err_q;
    assign err_sts           = err_sts_q;
    assign cmd_cnt           = cmd_cnt_q;
    assign m_axis_cmd_tdata  = cmd_dat_q;
    assign m_axis_cmd_tvalid = cmd_vld_q;
    assign s_axis_sts_tready = 1'b1;

endmodule

// File: doc/dm_cmd_sched.md
# dm_cmd_sched

Job-level command scheduler for one AXI DataMover channel (MM2S or S2MM; instantiate one per direction). It accepts a job (start address, total byte count, chunk size) from the register/control layer and splits it into 72-bit DataMover commands. It limits commands in flight to `MAX_OUTSTANDING`, consumes the status stream, and reports busy, done and error status. It sits between the AXI-Lite register block and the DataMover CMD/STS AXI-Stream ports, replacing free-running command issue.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 4: maximum commands accepted but not yet retired by status. Legal range 1..15.
- `CNT_WIDTH`, default 16: width of `cmd_cnt`.

Ports:
- `axi_aclk`  in  1  — single clock for all logic.
- `rst`  in  1  — synchronous, active-high reset.
- `job_saddr`  in  32  — job start byte address; sampled on `job_start`.
- `job_len`  in  32  — job total bytes; sampled on `job_start`.
- `job_chunk`  in  23  — bytes per command (BTT); sampled on `job_start`.
- `job_start`  in  1  — single-cycle pulse that starts a job.
- `job_abort`  in  1  — single-cycle pulse; stops issuing new commands.
- `busy`  out  1  — job in progress.
- `done`  out  1  — one-cycle pulse at job end.
- `err`  out  1  — sticky error flag; cleared by an accepted `job_start`.
- `err_sts`  out  8  — first erroneous status byte of the job.
- `cmd_cnt`  out  CNT_WIDTH  — commands accepted in this job; wraps.
- `m_axis_cmd_tdata`  out  72  — DataMover command.
- `m_axis_cmd_tvalid`  out  1  — command valid.
- `m_axis_cmd_tready`  in  1  — command ready.
- `s_axis_sts_tdata`  in  8  — DataMover status byte.
- `s_axis_sts_tvalid`  in  1  — status valid.
- `s_axis_sts_tready`  out  1  — status ready; constant 1.

## Operation
- **Command fields:** [71:68]=0; [67:64]=TAG=`cmd_cnt[3:0]`; [63:32]=SADDR; [31]=DRR=0; [30]=EOF; [29:24]=DSA=0; [23]=TYPE=1 (INCR); [22:0]=BTT.
- **Chunking:** BTT = min(remaining, chunk), with chunk zero-extended to 32 bits. EOF=1 only on the final chunk.
- **Address update:** after each handshake, addr += BTT and remaining -= BTT. Address arithmetic is modulo 2^32. No 4 KB boundary handling; the DataMover splits bursts itself.
- **Status decode:** [7]=OKAY, [6]=SLVERR, [5]=DECERR, [4]=INTERR, [3:0]=TAG. A beat is bad if OKAY=0 or any of [6:4] is set.
- **Outstanding counter:** +1 on each command handshake, −1 on each status beat. If both occur in the same cycle, the count is unchanged. The count saturates at 0.

State machine:
- **IDLE.** `job_start` with `job_chunk`=0 sets err=1, err_sts=0x00 and pulses done next cycle; no commands are issued. `job_start` with `job_len`=0 pulses done next cycle with err=0; no commands are issued. Otherwise the block latches the job, clears err, err_sts and cmd_cnt, and moves to ISSUE.
- **ISSUE.** `tvalid` is asserted while commands remain, outstanding_next < `MAX_OUTSTANDING`, and no stop condition has occurred. When the last chunk is accepted, go to DRAIN. On `job_abort` or a bad status beat, set a stop flag. A command already presented stays valid until accepted; AXIS valid is never retracted. After that, no new command is presented and the FSM goes to DRAIN.
- **DRAIN.** Wait until outstanding == 0, then go to DONE.
- **DONE.** Pulse `done` for one cycle, then go to IDLE.

Boundary conditions:
- A bad status beat sets err. `err_sts` captures only the first bad beat of the job.
- A status beat received while outstanding == 0 sets err (err_sts = that beat if it is the first error) and does not underflow the counter.
- `job_start` while busy is ignored.
- `job_abort` in IDLE or DRAIN is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `err_sts`=0, `cmd_cnt`=0, `m_axis_cmd_tvalid`=0, `m_axis_cmd_tdata`=0, outstanding=0, state=IDLE.
- Reset mid-job: `tvalid` drops in the first cycle after `rst` is sampled high. All job state is discarded.
- `job_start` sampled in cycle N: `busy`=1 and the first `tvalid` appear in cycle N+1.
- Back-to-back issue: handshake in cycle K allows the next command in cycle K+1, giving one command per cycle while below the limit.
- Flow control: if the handshake in cycle K makes outstanding reach `MAX_OUTSTANDING`, `tvalid`=0 in cycle K+1. A status beat in cycle S re-enables `tvalid` in cycle S+1.
- `m_axis_cmd_tdata` is registered and held stable while `tvalid` && !`tready`.
- The status beat that drains the last outstanding command in cycle S gives `done`=1 and `busy`=0 in cycle S+1. `busy` is high from N+1 through S.
- The zero-length or zero-chunk job case gives `done` in cycle N+1, with `busy` staying 0.

## Test plan
- **Basic split:** saddr=0x1000, len=3000, chunk=1024 → three commands: (0x1000, BTT 1024, EOF 0, TAG 0), (0x1400, 1024, 0, 1), (0x1800, 952, 1, 2). Return status 0x80/0x81/0x82 → `done` pulse, err=0, cmd_cnt=3.
- **Flow control:** MAX_OUTSTANDING=4, len=2048, chunk=256, status withheld → exactly 4 commands accepted, then `tvalid`=0. Each status beat releases exactly one more command. All 8 commands issued, then `done`.
- **Backpressure:** randomized `tready` (~50%) → `tdata` stable during every stall; address/BTT sequence identical to the no-stall case.
- **Error stop:** len=4096, chunk=1024; second status = 0x41 → err=1, err_sts=0x41, no commands presented after the stop, `done` after outstanding drains to 0.
- **Abort and ignores:** `job_abort` after 2 of 8 commands → at most one further (already-valid) command accepted, then `done`. `job_start` while busy → no effect. len=0 → `done` next cycle with no command.
- **Reset mid-job:** `rst` asserted mid-job → `tvalid`=0, `busy`=0, `cmd_cnt`=0 in the next cycle. A new job then runs correctly from TAG 0.
